// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 24-bit instruction format.
// Used by both the encoder/loader and the decoder.
package isa_pkg;

    localparam int OP_W  = 4;
    localparam int REG_W = 4;
    localparam int HDR_W = OP_W + REG_W;

    localparam logic [OP_W-1:0] OP_ALU_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_ALU_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_ALU_AND = 4'b0010;
    localparam logic [OP_W-1:0] OP_ALU_OR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_ALU_XOR = 4'b0100;
    localparam logic [OP_W-1:0] OP_ALU_SHL = 4'b0101;
    localparam logic [OP_W-1:0] OP_ALU_SHR = 4'b0110;
    localparam logic [OP_W-1:0] OP_ALU_MUL = 4'b0111;
    localparam logic [OP_W-1:0] OP_JMP     = 4'b1000;
    localparam logic [OP_W-1:0] OP_JCC     = 4'b1001;
    localparam logic [OP_W-1:0] OP_STORE   = 4'b1100;
    localparam logic [OP_W-1:0] OP_LOAD    = 4'b1101;
    localparam logic [OP_W-1:0] OP_MEM_PC  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'b00,
        ERR_ILLEGAL_OP = 2'b01,
        ERR_IMM_OVF    = 2'b10,
        ERR_FULL       = 2'b11
    } err_code_t;

    // Every 0xxx opcode is an ALU op; the upper half is sparsely populated.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        case (op)
            OP_JMP, OP_JCC, OP_STORE, OP_LOAD, OP_MEM_PC: return 1'b1;
            default: return !op[OP_W-1];
        endcase
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packing of one field set into an instruction word,
// with opcode legality and immediate range checks.
module instr_field_packer
    import isa_pkg::*;
#(
    parameter int N            = 24,
    parameter int registerSize = 32
) (
    input  logic [OP_W-1:0]         opcode,
    input  logic [REG_W-1:0]        reg_sel,
    input  logic [registerSize-1:0] imm,
    output logic [N-1:0]            word,
    output logic                    ok,
    output err_code_t               code
);

    localparam int IMM_W = N - HDR_W;

    logic illegal;
    logic ovf;

    assign word    = {opcode, reg_sel, imm[IMM_W-1:0]};
    assign illegal = !is_legal_op(opcode);
    assign ovf     = |imm[registerSize-1:IMM_W];
    assign ok      = !illegal && !ovf;

    // An illegal opcode outranks an oversized immediate.
    always_comb begin
        code = ERR_NONE;
        if (illegal) begin
            code = ERR_ILLEGAL_OP;
        end else if (ovf) begin
            code = ERR_IMM_OVF;
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams validated, packed instructions into instruction memory,
// one word per cycle, reporting completion or the first error.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int N            = 24,
    parameter int registerSize = 32,
    parameter int DEPTH        = 256,
    parameter int AW           = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         in_opcode,
    input  logic [REG_W-1:0]        in_reg,
    input  logic [registerSize-1:0] in_imm,
    input  logic                    in_last,
    output logic                    imem_we,
    output logic [AW-1:0]           imem_addr,
    output logic [N-1:0]            imem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic [AW:0]             word_count
);

    state_t    state;
    state_t    state_next;
    logic [N-1:0]  word;
    logic          ok;
    err_code_t     chk_code;
    logic [AW-1:0] addr;
    logic          accept;
    logic          good;
    logic          bad;
    logic          at_top;
    logic          restart;

    instr_field_packer #(
        .N            (N),
        .registerSize (registerSize)
    ) u_packer (
        .opcode  (in_opcode),
        .reg_sel (in_reg),
        .imm     (in_imm),
        .word    (word),
        .ok      (ok),
        .code    (chk_code)
    );

    assign accept  = in_valid && in_ready;
    assign good    = accept && ok;
    assign bad     = accept && !ok;
    assign at_top  = (addr == AW'(DEPTH - 1));
    assign restart = start && ((state == IDLE) || (state == ERR));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (bad) begin
                    state_next = ERR;
                end else if (good && in_last) begin
                    state_next = DONE;
                end else if (good && at_top) begin
                    state_next = ERR;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            ERR: begin
                if (start) state_next = RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A full image still commits its final word; only a bad field set is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr       <= '0;
            word_count <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            imem_we <= good;
            done    <= good && in_last;
            if (good) begin
                imem_addr  <= addr;
                imem_wdata <= word;
                addr       <= addr + 1'b1;
                word_count <= word_count + 1'b1;
            end
            if (restart) begin
                addr       <= '0;
                word_count <= '0;
                err        <= 1'b0;
                err_code   <= ERR_NONE;
            end else if (bad) begin
                err      <= 1'b1;
                err_code <= chk_code;
            end else if (good && !in_last && at_top) begin
                err      <= 1'b1;
                err_code <= ERR_FULL;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: vector table, directed corner
// sequences and random loads checked against a transaction-level model.
module tb_instr_encoder_loader;

    localparam int N     = 24;
    localparam int RS    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [3:0]    in_reg;
    logic [RS-1:0] in_imm;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [N-1:0]  imem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW:0]   word_count;

    instr_encoder_loader #(
        .N            (N),
        .registerSize (RS),
        .DEPTH        (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_reg     (in_reg),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Load-session model: what the host expects to see, not how it is built.
    bit          m_open;
    bit          m_in_done;
    bit          m_err;
    int          m_code;
    int          m_addr;
    int          m_count;
    bit          e_we;
    bit          e_done;
    int          e_addr;
    logic [23:0] e_data;

    int          wa_q[$];
    logic [23:0] wd_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rg;
        logic [31:0] imm;
        logic        last;
        logic        we;
        logic [23:0] wdata;
        logic        dn;
        logic [1:0]  code;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_in_done = 0; m_err = 0;
        m_code = 0; m_addr = 0; m_count = 0;
        e_we = 0; e_done = 0; e_addr = 0; e_data = '0;
    endtask

    task automatic model_step(input bit s, input bit v, input logic [3:0] op,
                              input logic [3:0] rg, input logic [31:0] imm,
                              input bit lst);
        bit acc;
        bit ill;
        bit ovf;
        e_we = 0;
        e_done = 0;
        acc = v && m_open;
        ill = (op == 4'hA) || (op == 4'hB) || (op == 4'hE);
        ovf = imm > 32'hFFFF;
        if (m_in_done) begin
            m_in_done = 0;
        end else if (acc && !ill && !ovf) begin
            e_we = 1;
            e_addr = m_addr;
            e_data = {op, rg, imm[15:0]};
            m_addr = (m_addr + 1) % DEPTH;
            m_count++;
            if (lst) begin
                m_open = 0; m_in_done = 1; e_done = 1;
            end else if (m_count == DEPTH) begin
                m_open = 0; m_err = 1; m_code = 3;
            end
        end else if (acc) begin
            m_open = 0; m_err = 1; m_code = ill ? 1 : 2;
        end else if (s && !m_open) begin
            m_open = 1; m_err = 0; m_code = 0; m_addr = 0; m_count = 0;
        end
    endtask

    task automatic cyc(input bit s, input bit v, input logic [3:0] op,
                       input logic [3:0] rg, input logic [31:0] imm,
                       input bit lst);
        start = s; in_valid = v; in_opcode = op;
        in_reg = rg; in_imm = imm; in_last = lst;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_open});
        model_step(s, v, op, rg, imm, lst);
        @(posedge clk);
        #1;
        chk("imem_we", {31'd0, imem_we}, {31'd0, e_we});
        if (e_we) begin
            chk("imem_addr", 32'(imem_addr), 32'(e_addr));
            chk("imem_wdata", 32'(imem_wdata), 32'(e_data));
        end
        chk("done", {31'd0, done}, {31'd0, e_done});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("err_code", 32'(err_code), 32'(m_code));
        chk("word_count", 32'(word_count), 32'(m_count));
        chk("busy", {31'd0, busy}, {31'd0, (m_open || m_in_done || m_err)});
        if (imem_we) begin
            wa_q.push_back(int'(imem_addr));
            wd_q.push_back(imem_wdata);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 4'h0, 4'h0, 32'h0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'h1, 4'h5, 32'h0000_1234, 1'b1, 1'b1, 24'h151234, 1'b1, 2'd0};
        tbl[1] = '{4'hA, 4'h0, 32'h0000_0000, 1'b1, 1'b0, 24'h000000, 1'b0, 2'd1};
        tbl[2] = '{4'hC, 4'h2, 32'h0001_0000, 1'b1, 1'b0, 24'h000000, 1'b0, 2'd2};
        tbl[3] = '{4'hC, 4'h2, 32'h0000_FFFF, 1'b1, 1'b1, 24'hC2FFFF, 1'b1, 2'd0};
        tbl[4] = '{4'hB, 4'h3, 32'h0002_0000, 1'b1, 1'b0, 24'h000000, 1'b0, 2'd1};
        tbl[5] = '{4'hE, 4'h1, 32'h0000_0005, 1'b0, 1'b0, 24'h000000, 1'b0, 2'd1};
        tbl[6] = '{4'hF, 4'h0, 32'h0000_0000, 1'b1, 1'b1, 24'hF00000, 1'b1, 2'd0};
        tbl[7] = '{4'h7, 4'hF, 32'h0000_ABCD, 1'b1, 1'b1, 24'h7FABCD, 1'b1, 2'd0};
        tbl[8] = '{4'h9, 4'h0, 32'h8000_0000, 1'b1, 1'b0, 24'h000000, 1'b0, 2'd2};

        rst = 1; start = 0; in_valid = 0; in_opcode = 0;
        in_reg = 0; in_imm = 0; in_last = 0;
        model_reset();
        #1;
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {29'd0, err, err_code}, 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        #11;
        rst = 0;

        foreach (tbl[i]) begin
            cyc(1, 0, 4'h0, 4'h0, 32'h0, 0);
            cyc(0, 1, tbl[i].op, tbl[i].rg, tbl[i].imm, tbl[i].last);
            chk("tbl_we", {31'd0, imem_we}, {31'd0, tbl[i].we});
            if (tbl[i].we) begin
                chk("tbl_addr", 32'(imem_addr), 32'd0);
                chk("tbl_wdata", 32'(imem_wdata), 32'(tbl[i].wdata));
                chk("tbl_wc", 32'(word_count), 32'd1);
            end
            chk("tbl_done", {31'd0, done}, {31'd0, tbl[i].dn});
            chk("tbl_err", {31'd0, err}, {31'd0, (tbl[i].code != 2'd0)});
            chk("tbl_code", 32'(err_code), 32'(tbl[i].code));
            idle(2);
            if (tbl[i].we) chk("tbl_idle", {31'd0, busy}, 32'd0);
        end

        // Image full without in_last
        wa_q.delete();
        cyc(1, 0, 4'h0, 4'h0, 32'h0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 4'h2, 4'h1, 32'(i), 0);
        for (int i = 0; i < DEPTH; i++) chk("full_addr", 32'(wa_q[i]), 32'(i));
        chk("full_code", 32'(err_code), 32'd3);
        chk("full_wc", 32'(word_count), 32'(DEPTH));
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        idle(1);

        // Valid gaps leave no address holes
        wa_q.delete();
        cyc(1, 0, 4'h0, 4'h0, 32'h0, 0);
        cyc(0, 1, 4'h3, 4'h1, 32'h11, 0);
        cyc(0, 0, 4'h3, 4'h1, 32'h22, 0);
        cyc(0, 1, 4'h3, 4'h2, 32'h33, 0);
        cyc(0, 1, 4'h3, 4'h3, 32'h44, 1);
        chk("gap_done", {31'd0, done}, 32'd1);
        chk("gap_n", 32'(wa_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("gap_addr", 32'(wa_q[i]), 32'(i));
        idle(2);

        // Asynchronous reset while a write is being presented
        cyc(1, 0, 4'h0, 4'h0, 32'h0, 0);
        cyc(0, 1, 4'h0, 4'h6, 32'h77, 0);
        #2 rst = 1;
        #1;
        chk("arst_we", {31'd0, imem_we}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_wc", 32'(word_count), 32'd0);
        chk("arst_out", {imem_wdata, 6'd0, imem_addr}, 32'd0);
        model_reset();
        #2 rst = 0;
        wa_q.delete();
        cyc(1, 0, 4'h0, 4'h0, 32'h0, 0);
        cyc(0, 1, 4'h0, 4'h6, 32'h78, 1);
        chk("arst_restart_addr", 32'(wa_q[0]), 32'd0);
        idle(2);

        // Round trip through the decoder's field view
        wd_q.delete();
        cyc(1, 0, 4'h0, 4'h0, 32'h0, 0);
        cyc(0, 1, 4'hC, 4'h4, 32'h10, 0);
        cyc(0, 1, 4'h8, 4'h8, 32'h20, 1);
        chk("rt_memwrite", {31'd0, (wd_q[0][23:20] == 4'b1100)}, 32'd1);
        chk("rt_reg4", 32'(wd_q[0][19:16]), 32'd4);
        chk("rt_pcwe", (wd_q[1][23:20] == 4'b1000) ? 32'b010 : 32'b000, 32'b010);
        chk("rt_reg8", 32'(wd_q[1][19:16]), 32'd8);
        idle(2);

        // Random loads, with stray starts and occasional bad fields
        for (int ld = 0; ld < 60; ld++) begin
            int k;
            k = $urandom_range(1, 6);
            cyc(1, 0, 4'h0, 4'h0, 32'h0, 0);
            for (int w = 0; w < k; w++) begin
                logic [31:0] imm;
                while ($urandom_range(0, 3) == 0)
                    cyc($urandom_range(0, 7) == 0, 0, 4'h0, 4'h0, 32'h0, 0);
                imm = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF);
                cyc($urandom_range(0, 7) == 0, 1, 4'($urandom), 4'($urandom),
                    imm, w == k - 1);
            end
            idle($urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
